timer_prescaler_ctrl: RTL and testbench
=======================================

# timer_prescaler_ctrl

Shared prescaler and clock-select controller for the ATMega32A Timer0/Timer1 pair. It owns one free-running 10-bit prescaler counter and gives each timer channel a single-cycle count-enable tick, selected by that channel's CS[2:0] field. Sources are: stopped, clk, clk/8, clk/64, clk/256, clk/1024, or the external T0/T1 pin (falling or rising edge). The timers run on the system clock and advance only when their tick is high; no derived clocks are generated.

## Interface
- PRESC_W, 10, prescaler counter width; must be at least 10.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- cs0  in  3  Timer0 clock select (TCCR0.CS0[2:0]).
- cs1  in  3  Timer1 clock select (TCCR1B.CS1[2:0]).
- psr_wr  in  1  single-cycle strobe; writing 1 to SFIOR.PSR10 clears the shared prescaler.
- t0_pin  in  1  asynchronous external clock pin for Timer0.
- t1_pin  in  1  asynchronous external clock pin for Timer1.
- tick0  out  1  registered count enable for Timer0.
- tick1  out  1  registered count enable for Timer1.
- presc_cnt  out  PRESC_W  current prescaler value, for debug and the bench.

## Operation
- **Prescaler counter**
  - Runs continuously, independent of cs0/cs1, and wraps from 1023 to 0.
  - psr_wr=1 loads 0 on the next edge. psr_wr takes priority over increment.
- **Per-channel decode (same logic for channel 0 and channel 1)**
  - 000: no tick.
  - 001: tick every cycle.
  - 010 / 011 / 100 / 101: tick when presc_cnt[k-1:0] is all ones, with k = 3 / 6 / 8 / 10.
  - 110: tick on a synchronized falling edge of the channel's pin.
  - 111: tick on a synchronized rising edge of the channel's pin.
- **psr_wr in a cycle that would produce a prescaled tick:** the tick is suppressed, because the partial period is discarded. Ticks from codes 001, 110 and 111 are not affected by psr_wr.
- **External pin path**
  - 2-flop synchronizer, then a previous-value register, then edge compare.
  - All three flops reset to 0.
  - Edge detection is masked for 3 cycles after reset release by a 2-bit arm counter, so a pin held high through reset produces no false rising edge.
  - Pin pulses shorter than one clk period high or low may be missed. This is legal; the AVR has the same limitation.
- **CS changes**
  - A new cs value is used from the cycle it is presented. There is no resync of the prescaler phase.
  - Switching between prescaled taps can therefore shorten the first period. This is intended (matches AVR).
  - Switching into 110/111 does not generate a tick from stale edge history: the edge registers run continuously regardless of cs.
- **Simultaneous events:** both channels may tick in the same cycle. The channels are fully independent except for the shared counter and psr_wr.

## Timing
- **Reset:** tick0=0, tick1=0, presc_cnt=0, arm counter=0.
- **Cycle numbering:** cycle 0 is the first edge with rst_n=1. presc_cnt is 0 during cycle 0 and increments at each edge.
- **Tick latency:** each tick is registered, so it is high in the cycle after its decode condition.
  - clk/8 first tick: cycle 8.
  - clk/8 period: exactly 8 cycles thereafter.
  - clk/N in general: first tick at cycle N, then period N.
- **cs=001:** tick high from cycle 1 onward, continuously.
- **External edge:** the pin edge, sampled at edge e, gives a tick in cycle e+3 (2 sync stages, 1 output register). The tick is exactly 1 cycle wide per pin edge.
- **psr_wr:** asserted in cycle p gives presc_cnt=0 in cycle p+1. The next clk/8 tick is in cycle p+9.
- **rst_n low mid-operation:** outputs clear on the next edge; any pending edge in the pipeline is dropped.

## Structure
- Shared package/header `timer_pkg` holds:
  - CS encoding constants: CS_STOP, CS_CLK1, CS_CLK8, CS_CLK64, CS_CLK256, CS_CLK1024, CS_EXT_FALL, CS_EXT_RISE.
  - PRESC_W default.
  - Tap index constants 3/6/8/10.
- One sub-module, `ext_clk_sync`: synchronizer, edge detect and arm mask; outputs `rise` and `fall` pulses.
  - Instantiated twice, for t0_pin and t1_pin.
- Top level contains:
  - the counter;
  - one decode function, shared by both channels;
  - the two output registers.

## Test plan
- **Reset release:** cs0=010, cs1=101, pins low. Expect tick0 in cycles 8, 16, 24. Expect the first tick1 in cycle 1024. presc_cnt=0 in cycle 0.
- **cs0=001, cs1=000:** tick0 high every cycle from cycle 1; tick1 never asserts over 2048 cycles.
- **cs0=011, psr_wr pulsed when presc_cnt=63 (cycle 63):** no tick0 in cycle 64. presc_cnt=0 in cycle 64. Next tick0 in cycle 128.
- **cs0=111, cs1=110, t0_pin and t1_pin driven with the same 0→1→0 pulse (each level held 4 cycles):**
  - tick0 is 1 cycle wide, 3 cycles after the rise is sampled.
  - tick1 is 1 cycle wide, 3 cycles after the fall is sampled.
- **t0_pin held high through reset, cs0=111:** no tick0 after reset release. The first tick0 comes only after a genuine 0→1 transition.
- **Live switch of cs0 from 101 to 010 at presc_cnt=5:** the next tick0 occurs when presc_cnt[2:0]=7, in the cycle after presc_cnt=7, with no spurious extra pulse.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the Timer0/Timer1 prescaler and clock-select logic.
package timer_pkg;

  typedef enum logic [2:0] {
    CS_STOP     = 3'b000,
    CS_CLK1     = 3'b001,
    CS_CLK8     = 3'b010,
    CS_CLK64    = 3'b011,
    CS_CLK256   = 3'b100,
    CS_CLK1024  = 3'b101,
    CS_EXT_FALL = 3'b110,
    CS_EXT_RISE = 3'b111
  } cs_e;

  localparam int unsigned PRESC_W_DEFAULT = 10;
  localparam int unsigned PRESC_MAX       = 1023;

  localparam int unsigned TAP_8    = 3;
  localparam int unsigned TAP_64   = 6;
  localparam int unsigned TAP_256  = 8;
  localparam int unsigned TAP_1024 = 10;

endpackage

// File: rtl/ext_clk_sync.sv
// External timer pin synchronizer and edge detector with post-reset arm mask.
module ext_clk_sync
  import timer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic [1:0] arm;
  logic       armed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      arm   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      prev  <= sync2;
      if (!armed)
        arm <= arm + 2'd1;
    end
  end

  // Edges are ignored until the synchronizer has flushed its reset values.
  assign armed = (arm == 2'd3);

  always_comb begin
    rise = armed & sync2 & ~prev;
    fall = armed & ~sync2 & prev;
  end

endmodule

// File: rtl/timer_prescaler_ctrl.sv
// Shared prescaler counter and per-channel clock-select decode for Timer0/Timer1.
module timer_prescaler_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned PRESC_W = PRESC_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         cs0,
  input  logic [2:0]         cs1,
  input  logic               psr_wr,
  input  logic               t0_pin,
  input  logic               t1_pin,
  output logic               tick0,
  output logic               tick1,
  output logic [PRESC_W-1:0] presc_cnt
);

  logic rise0, fall0, rise1, fall1;
  logic tick0_d, tick1_d;

  // A pending prescaled tick is dropped when the prescaler is being cleared.
  function automatic logic tick_decode(input logic [2:0]         cs,
                                       input logic [PRESC_W-1:0] cnt,
                                       input logic               psr,
                                       input logic               rise,
                                       input logic               fall);
    logic t;
    t = 1'b0;
    case (cs_e'(cs))
      CS_STOP:     t = 1'b0;
      CS_CLK1:     t = 1'b1;
      CS_CLK8:     t = (&cnt[TAP_8-1:0])    & ~psr;
      CS_CLK64:    t = (&cnt[TAP_64-1:0])   & ~psr;
      CS_CLK256:   t = (&cnt[TAP_256-1:0])  & ~psr;
      CS_CLK1024:  t = (&cnt[TAP_1024-1:0]) & ~psr;
      CS_EXT_FALL: t = fall;
      CS_EXT_RISE: t = rise;
      default:     t = 1'b0;
    endcase
    return t;
  endfunction

  ext_clk_sync u_sync0 (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (t0_pin),
    .rise  (rise0),
    .fall  (fall0)
  );

  ext_clk_sync u_sync1 (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (t1_pin),
    .rise  (rise1),
    .fall  (fall1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)
      presc_cnt <= '0;
    else if (psr_wr)
      presc_cnt <= '0;
    else if (presc_cnt == PRESC_W'(PRESC_MAX))
      presc_cnt <= '0;
    else
      presc_cnt <= presc_cnt + 1'b1;
  end

  always_comb begin
    tick0_d = tick_decode(cs0, presc_cnt, psr_wr, rise0, fall0);
    tick1_d = tick_decode(cs1, presc_cnt, psr_wr, rise1, fall1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick0 <= 1'b0;
      tick1 <= 1'b0;
    end else begin
      tick0 <= tick0_d;
      tick1 <= tick1_d;
    end
  end

endmodule

// File: tb/tb_timer_prescaler_ctrl.sv
// Self-checking bench for timer_prescaler_ctrl: cycle model plus directed literal checks.
`timescale 1ns/1ps
module tb_timer_prescaler_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] cs0 = 3'b000;
  logic [2:0] cs1 = 3'b000;
  logic       psr_wr = 1'b0;
  logic       t0_pin = 1'b0;
  logic       t1_pin = 1'b0;
  logic       tick0, tick1;
  logic [9:0] presc_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  timer_prescaler_ctrl #(.PRESC_W(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cs0       (cs0),
    .cs1       (cs1),
    .psr_wr    (psr_wr),
    .t0_pin    (t0_pin),
    .t1_pin    (t1_pin),
    .tick0     (tick0),
    .tick1     (tick1),
    .presc_cnt (presc_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: cycle counts and pin sample history, no RTL structure.
  bit mvalid = 0;
  int mcnt;
  int mcyc;
  bit e_t0, e_t1;
  int e_cnt;
  bit p0[3];
  bit p1[3];

  function automatic bit mexp(input int cs, input int m, input bit psr, input bit r, input bit f);
    case (cs)
      0: return 0;
      1: return 1;
      2: return !psr && (m % 8 == 7);
      3: return !psr && (m % 64 == 63);
      4: return !psr && (m % 256 == 255);
      5: return !psr && (m % 1024 == 1023);
      6: return f;
      default: return r;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mcnt = 0; mcyc = 0; e_t0 = 0; e_t1 = 0; e_cnt = 0; mvalid = 1;
        for (int i = 0; i < 3; i++) begin p0[i] = 0; p1[i] = 0; end
      end else begin
        // p*[1] is the pin sampled two edges ago, p*[2] three edges ago
        bit armd, r0, f0, r1, f1;
        armd = (mcyc >= 3);
        r0 = armd && p0[1] && !p0[2];
        f0 = armd && !p0[1] && p0[2];
        r1 = armd && p1[1] && !p1[2];
        f1 = armd && !p1[1] && p1[2];
        e_t0 = mexp(int'(cs0), mcnt, psr_wr, r0, f0);
        e_t1 = mexp(int'(cs1), mcnt, psr_wr, r1, f1);
        mcnt = psr_wr ? 0 : (mcnt + 1) % 1024;
        e_cnt = mcnt;
        p0[2] = p0[1]; p0[1] = p0[0]; p0[0] = t0_pin;
        p1[2] = p1[1]; p1[1] = p1[0]; p1[0] = t1_pin;
        mcyc++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        check("model_tick0", int'(tick0), int'(e_t0));
        check("model_tick1", int'(tick1), int'(e_t1));
        check("model_cnt", int'(presc_cnt), e_cnt);
      end
    end
  end

  // Directed-test bookkeeping: cycle index and logged tick cycles.
  int tcyc;
  int q0[$];
  int q1[$];

  task automatic step();
    @(negedge clk);
    tcyc++;
    if (tick0) q0.push_back(tcyc);
    if (tick1) q1.push_back(tcyc);
  endtask

  task automatic run_to(input int c);
    while (tcyc < c) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tcyc = 0;
    q0.delete();
    q1.delete();
  endtask

  function automatic int qat(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    // Reset release, clk/8 and clk/1024
    cs0 = 3'b010; cs1 = 3'b101;
    do_reset();
    check("t1_cnt_c0", int'(presc_cnt), 0);
    check("t1_tick0_c0", int'(tick0), 0);
    check("t1_tick1_c0", int'(tick1), 0);
    run_to(1023);
    check("t1_cnt_c1023", int'(presc_cnt), 1023);
    run_to(1024);
    check("t1_cnt_wrap", int'(presc_cnt), 0);
    run_to(1030);
    check("t1_tick0_first", qat(q0, 0), 8);
    check("t1_tick0_second", qat(q0, 1), 16);
    check("t1_tick0_third", qat(q0, 2), 24);
    check("t1_tick1_first", qat(q1, 0), 1024);
    check("t1_tick1_count", q1.size(), 1);

    // Every-cycle tick and stopped channel
    cs0 = 3'b001; cs1 = 3'b000;
    do_reset();
    check("t2_tick0_c0", int'(tick0), 0);
    step();
    check("t2_tick0_c1", int'(tick0), 1);
    run_to(2048);
    check("t2_tick0_count", q0.size(), 2048);
    check("t2_tick1_count", q1.size(), 0);

    // Prescaler clear at presc_cnt=63 with clk/64
    cs0 = 3'b011; cs1 = 3'b000;
    do_reset();
    run_to(63);
    check("t3_cnt_c63", int'(presc_cnt), 63);
    psr_wr = 1'b1;
    step();
    psr_wr = 1'b0;
    check("t3_tick0_c64", int'(tick0), 0);
    check("t3_cnt_c64", int'(presc_cnt), 0);
    run_to(130);
    check("t3_tick0_count", q0.size(), 1);
    check("t3_tick0_next", qat(q0, 0), 128);

    // External rise on channel 0, fall on channel 1
    cs0 = 3'b111; cs1 = 3'b110;
    do_reset();
    run_to(10);
    t0_pin = 1'b1; t1_pin = 1'b1;
    run_to(14);
    t0_pin = 1'b0; t1_pin = 1'b0;
    run_to(30);
    check("t4_tick0_count", q0.size(), 1);
    check("t4_tick0_cycle", qat(q0, 0), 13);
    check("t4_tick1_count", q1.size(), 1);
    check("t4_tick1_cycle", qat(q1, 0), 17);

    // Pin high through reset gives no false rising edge
    cs0 = 3'b111; cs1 = 3'b000;
    t0_pin = 1'b1;
    do_reset();
    run_to(20);
    check("t5_no_false_rise", q0.size(), 0);
    t0_pin = 1'b0;
    run_to(25);
    t0_pin = 1'b1;
    run_to(40);
    check("t5_tick0_count", q0.size(), 1);
    check("t5_tick0_cycle", qat(q0, 0), 28);

    // Live switch clk/1024 -> clk/8 at presc_cnt=5
    cs0 = 3'b101; t0_pin = 1'b0;
    do_reset();
    run_to(1029);
    check("t6_cnt_c1029", int'(presc_cnt), 5);
    cs0 = 3'b010;
    run_to(1040);
    check("t6_tick0_count", q0.size(), 3);
    check("t6_tick0_1024", qat(q0, 0), 1024);
    check("t6_tick0_after_switch", qat(q0, 1), 1032);
    check("t6_tick0_period", qat(q0, 2), 1040);

    // Reset mid-operation drops a pending external edge
    cs0 = 3'b111;
    do_reset();
    run_to(10);
    t0_pin = 1'b1;
    run_to(11);
    do_reset();
    check("t7_tick0_c0", int'(tick0), 0);
    check("t7_cnt_c0", int'(presc_cnt), 0);
    run_to(15);
    check("t7_pending_dropped", q0.size(), 0);
    t0_pin = 1'b0;
    run_to(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
